frame_config_loader: RTL and testbench
======================================

# frame_config_loader

Configuration-side counterpart of the frame-configured BELs and switch matrices: it consumes a 32-bit bitstream word stream and drives the frame data and frame strobe lines whose latches produce every `ConfigBits` vector in a fabric column. The loader sits between the bitstream source and the column frame latches. It parses sync, header and data words, and fires one one-hot frame strobe per data word. It reports completion and protocol errors to the configuration controller.

## Interface
- `FrameBitsPerRow`, 32, width of one frame data word; fixed at 32 and equal to the bitstream word width.
- `MaxFramesPerCol`, 20, number of frame strobe lines per column.
- `NumColumns`, 16, number of addressable columns.
- `CLK` input 1: the single clock.
- `resetn` input 1: reset, asynchronous, active-low.
- `WriteData` input 32: bitstream word.
- `WriteStrobe` input 1: `WriteData` valid.
- `Ready` output 1: the word is accepted on a rising edge where `WriteStrobe && Ready`.
- `FrameData` output FrameBitsPerRow: frame payload to the column latches.
- `FrameStrobe` output MaxFramesPerCol: one-hot write pulse, 1 cycle.
- `ColumnSelect` output $clog2(NumColumns): target column, valid while `FrameStrobe` is nonzero.
- `ConfigDone` output 1: level; set by the desync word, cleared by the sync word.
- `Error` output 1: sticky protocol error; cleared by the sync word or reset.

## Operation
- **Constants**
  - SYNC = 32'hFAB0_FAB1.
  - DESYNC = 32'hFAB0_FAB0.
- **Header word fields**
  - [31:24] column.
  - [23:16] first frame index.
  - [15:0] frame count N.
- **States:** IDLE, HDR, LOAD, STROBE, ERR.
- **IDLE**
  - Accepts and discards every word except SYNC.
  - SYNC moves to HDR, clears `Error` and `ConfigDone`.
- **HDR**
  - SYNC is ignored; stays in HDR.
  - DESYNC sets `ConfigDone` and moves to IDLE.
  - A header with N=0 is a no-op; stays in HDR.
  - A header with column >= NumColumns, first index >= MaxFramesPerCol, or first index + N > MaxFramesPerCol sets `Error` and moves to ERR.
  - Any other header latches column, frame index and remaining count = N, and moves to LOAD.
- **LOAD**
  - Every accepted word is raw payload; sync/desync values are not decoded here.
  - On the accepting edge: `FrameData` <= word, `FrameStrobe` <= onehot(frame index), state moves to STROBE.
- **STROBE**
  - Lasts exactly one cycle with `Ready`=0.
  - On exit: `FrameStrobe` <= 0, frame index += 1, remaining -= 1.
  - Next state is HDR if remaining reaches 0, else LOAD.
- **ERR**
  - Accepts and discards words until SYNC, which clears `Error` and moves to HDR.
- **Ready** is 1 in every state except STROBE.
- **Remaining count** is 16-bit and never wraps: the HDR range check guarantees the index stays < MaxFramesPerCol.

## Timing
- **Reset values:** `Ready`=0 while `resetn` is low and 1 from the first edge after release; `FrameData`=0, `FrameStrobe`=0, `ColumnSelect`=0, `ConfigDone`=0, `Error`=0, state IDLE.
- **Strobe latency:** if a data word is accepted at edge t, `FrameStrobe` is high from t to t+1 with `FrameData` already stable. The cycle after t+1 is the earliest next accept. Sustained throughput is one frame per 2 cycles.
- **FrameData hold:** `FrameData` holds its value until the next LOAD accept, so it is stable for at least 1 cycle after the strobe falls.
- **ColumnSelect** updates only on header acceptance.
- **Idle input:** `WriteStrobe` low in any state means no state change (STROBE still exits after its one cycle).
- **Reset mid-frame:** asserting `resetn` low during STROBE drops the strobe immediately (asynchronous); the partial frame is not retried.

## Structure
- **Shared package** `fabulous_config_pkg`:
  - SYNC/DESYNC constants.
  - Header field positions.
  - The state enum, also used by the config UART front-end.
- **Sub-module** `frame_strobe_decoder`: registered one-hot decode of the frame index with an enable input, parameterised by MaxFramesPerCol.
- **Loader top level:** FSM, counters and header checks.

## Test plan
- **Basic frame write:** SYNC, header 0x03_05_0002, words A5A5A5A5, 5A5A5A5A → `FrameStrobe`=1<<5 with `FrameData`=A5A5A5A5, then 1<<6 with 5A5A5A5A; `ColumnSelect`=3; state returns to HDR.
- **Back-to-back throughput:** `WriteStrobe` held high through 4 data words → `Ready` toggles 1,0,1,0…; exactly 4 strobes on consecutive even cycles.
- **Range errors:** header 0x00_13_0002 with MaxFramesPerCol=20 → `Error`=1, no strobe, words ignored. A following SYNC → `Error`=0 and HDR.
- **Payload equals desync value:** data word equal to 32'hFAB0_FAB0 inside LOAD → written as payload, `ConfigDone` stays 0. DESYNC in HDR → `ConfigDone`=1.
- **Reset mid-frame:** `resetn` pulsed low during STROBE → `FrameStrobe` drops in the same cycle, all outputs return to reset values, and subsequent words are ignored until SYNC.
- **Degenerate header:** N=0 header then DESYNC → no strobe, `ConfigDone`=1.

Source files
------------

// File: rtl/fabulous_config_pkg.sv
// fabulous_config_pkg: bitstream constants, header field layout and the loader state enum
package fabulous_config_pkg;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;
  localparam int COL_LSB = 24;
  localparam int COL_W = 8;
  localparam int IDX_LSB = 16;
  localparam int IDX_W = 8;
  localparam int CNT_LSB = 0;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {IDLE, HDR, LOAD, STROBE, ERR} cfg_state_e;
endpackage

// File: rtl/frame_strobe_decoder.sv
// frame_strobe_decoder: registered one-hot decode of a frame index, cleared whenever not enabled
module frame_strobe_decoder #(
  parameter int MaxFramesPerCol = 20,
  parameter int IW = $clog2(MaxFramesPerCol)
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic                       en,
  input  logic [IW-1:0]              idx,
  output logic [MaxFramesPerCol-1:0] strobe
);
  // one-cycle pulse: the strobe only survives the cycle right after an enabled edge
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) strobe <= '0;
    else strobe <= en ? MaxFramesPerCol'(1) << idx : '0;
endmodule

// File: rtl/frame_config_loader.sv
// frame_config_loader: parses sync/header/data bitstream words and fires one-hot frame strobes per column
module frame_config_loader
  import fabulous_config_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns = 16
) (
  input  logic                          CLK,
  input  logic                          resetn,
  input  logic [31:0]                   WriteData,
  input  logic                          WriteStrobe,
  output logic                          Ready,
  output logic [FrameBitsPerRow-1:0]    FrameData,
  output logic [MaxFramesPerCol-1:0]    FrameStrobe,
  output logic [$clog2(NumColumns)-1:0] ColumnSelect,
  output logic                          ConfigDone,
  output logic                          Error
);
  localparam int CW = $clog2(NumColumns);
  localparam int IW = $clog2(MaxFramesPerCol);
  cfg_state_e state, state_nxt;
  logic out_of_reset, accept, is_sync, is_desync, is_hdr, hdr_bad, hdr_ok, load_accept;
  logic [COL_W-1:0] hdr_col;
  logic [IDX_W-1:0] hdr_idx;
  logic [CNT_W-1:0] hdr_cnt, remaining;
  logic [IW-1:0] frame_idx;
  assign accept = WriteStrobe && Ready;
  assign is_sync = WriteData == SYNC;
  assign is_desync = WriteData == DESYNC;
  assign hdr_col = WriteData[COL_LSB +: COL_W];
  assign hdr_idx = WriteData[IDX_LSB +: IDX_W];
  assign hdr_cnt = WriteData[CNT_LSB +: CNT_W];
  assign is_hdr = state == HDR && accept && !is_sync && !is_desync && hdr_cnt != '0;
  assign hdr_bad = hdr_col >= COL_W'(NumColumns) || hdr_idx >= IDX_W'(MaxFramesPerCol) ||
                   17'(hdr_idx) + 17'(hdr_cnt) > 17'(MaxFramesPerCol);
  assign hdr_ok = is_hdr && !hdr_bad;
  assign load_accept = state == LOAD && accept;
  // state register
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nxt;
  // next-state decode; sync/desync are only decoded outside LOAD
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && is_sync) state_nxt = HDR;
      HDR: if (accept && !is_sync) state_nxt = is_desync ? IDLE : hdr_cnt == '0 ? HDR : hdr_bad ? ERR : LOAD;
      LOAD: if (accept) state_nxt = STROBE;
      STROBE: state_nxt = remaining == CNT_W'(1) ? HDR : LOAD;
      ERR: if (accept && is_sync) state_nxt = HDR;
      default: state_nxt = IDLE;
    endcase
  end
  // ready is held low through reset and during the strobe cycle
  always_comb Ready = out_of_reset && state != STROBE;
  // header latches, frame counters, payload and status flags
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) begin
      out_of_reset <= 1'b0;
      frame_idx <= '0;
      remaining <= '0;
      ColumnSelect <= '0;
      FrameData <= '0;
      ConfigDone <= 1'b0;
      Error <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      if (hdr_ok) begin
        ColumnSelect <= hdr_col[CW-1:0];
        frame_idx <= hdr_idx[IW-1:0];
        remaining <= hdr_cnt;
      end
      if (state == STROBE) begin
        frame_idx <= frame_idx + IW'(1);
        remaining <= remaining - CNT_W'(1);
      end
      if (load_accept) FrameData <= WriteData;
      if (accept && is_sync && (state == IDLE || state == ERR)) begin
        Error <= 1'b0;
        ConfigDone <= 1'b0;
      end
      if (accept && state == HDR && is_desync) ConfigDone <= 1'b1;
      if (is_hdr && hdr_bad) Error <= 1'b1;
    end
  frame_strobe_decoder #(.MaxFramesPerCol(MaxFramesPerCol)) u_strobe_dec (
    .CLK(CLK),
    .resetn(resetn),
    .en(load_accept),
    .idx(frame_idx),
    .strobe(FrameStrobe)
  );
endmodule

// File: tb/tb_frame_config_loader.sv
// tb_frame_config_loader: directed and randomized bitstream stimulus checked against a protocol-level model
module tb_frame_config_loader;
  localparam logic [31:0] W_SYNC = 32'hFAB0_FAB1;
  localparam logic [31:0] W_DESYNC = 32'hFAB0_FAB0;
  logic CLK = 1'b0;
  logic resetn = 1'b1;
  logic WriteStrobe = 1'b0;
  logic [31:0] WriteData = '0;
  logic Ready, ConfigDone, Error;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic [3:0] ColumnSelect;
  int n_cmp = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  // protocol model: mode 0=waiting for sync, 1=expecting header, 2=expecting data, 3=error
  int m_mode, m_col, m_idx, m_rem;
  logic [31:0] m_data;
  bit m_done, m_err, m_rdy, m_in_strobe;

  frame_config_loader dut (
    .CLK(CLK), .resetn(resetn), .WriteData(WriteData), .WriteStrobe(WriteStrobe),
    .Ready(Ready), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
    .ColumnSelect(ColumnSelect), .ConfigDone(ConfigDone), .Error(Error)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_col = 0; m_idx = 0; m_rem = 0; m_data = '0;
    m_done = 0; m_err = 0; m_rdy = 0; m_in_strobe = 0;
  endtask

  // advance the model by one clock edge using the inputs that edge will see
  task automatic model_step();
    bit acc;
    int c, f, n;
    acc = WriteStrobe && m_rdy && !m_in_strobe;
    m_rdy = 1;
    c = int'(WriteData[31:24]);
    f = int'(WriteData[23:16]);
    n = int'(WriteData[15:0]);
    if (m_in_strobe) begin
      m_in_strobe = 0;
      m_idx = m_idx + 1;
      m_rem = m_rem - 1;
      m_mode = (m_rem == 0) ? 1 : 2;
    end else if (acc) begin
      if (m_mode == 0) begin
        if (WriteData == W_SYNC) begin m_mode = 1; m_done = 0; m_err = 0; end
      end else if (m_mode == 1) begin
        if (WriteData == W_SYNC) begin
        end else if (WriteData == W_DESYNC) begin
          m_done = 1; m_mode = 0;
        end else if (n == 0) begin
        end else if (c >= 16 || f >= 20 || f + n > 20) begin
          m_err = 1; m_mode = 3;
        end else begin
          m_col = c; m_idx = f; m_rem = n; m_mode = 2;
        end
      end else if (m_mode == 2) begin
        m_data = WriteData; m_in_strobe = 1;
      end else if (WriteData == W_SYNC) begin
        m_err = 0; m_mode = 1;
      end
    end
  endtask

  // compare every output on every falling edge, then step the model
  initial forever begin
    @(negedge CLK);
    if (!resetn) model_reset();
    check("Ready", 32'(Ready), 32'(m_rdy && !m_in_strobe));
    check("FrameStrobe", 32'(FrameStrobe), m_in_strobe ? (32'd1 << m_idx) : 32'd0);
    check("FrameData", FrameData, m_data);
    check("ColumnSelect", 32'(ColumnSelect), 32'(m_col));
    check("ConfigDone", 32'(ConfigDone), 32'(m_done));
    check("Error", 32'(Error), 32'(m_err));
    if (FrameStrobe != '0) strobe_cnt++;
    if (resetn) model_step();
  end

  task automatic send(input logic [31:0] w);
    bit ok;
    ok = 0;
    WriteData = w;
    WriteStrobe = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      if (Ready) ok = 1;
    end
    check("send_ready_wait", 32'(ok), 32'd1);
    @(posedge CLK);
    #2;
  endtask

  task automatic idle();
    WriteStrobe = 1'b0;
  endtask

  task automatic peek_start();
    @(negedge CLK);
    #1;
  endtask

  task automatic peek_end();
    @(posedge CLK);
    #2;
  endtask

  function automatic logic [31:0] rand_word();
    int r;
    r = $urandom_range(0, 19);
    if (r < 2) return W_SYNC;
    if (r == 2) return W_DESYNC;
    if (r < 10) return {8'($urandom_range(0, 17)), 8'($urandom_range(0, 21)), 16'($urandom_range(0, 4))};
    if (r == 10) return {8'($urandom_range(0, 15)), 8'($urandom_range(0, 19)), 16'($urandom)};
    return $urandom;
  endfunction

  initial begin
    int s0;
    #1 resetn = 1'b0;
    peek_start();
    check("rst_Ready", 32'(Ready), 32'd0);
    check("rst_FrameStrobe", 32'(FrameStrobe), 32'd0);
    check("rst_ConfigDone", 32'(ConfigDone), 32'd0);
    check("rst_Error", 32'(Error), 32'd0);
    peek_end();
    resetn = 1'b1;
    peek_start();
    check("ready_before_first_edge", 32'(Ready), 32'd0);
    peek_start();
    check("ready_after_first_edge", 32'(Ready), 32'd1);
    peek_end();
    // words before SYNC are discarded
    send(32'h0305_0002);
    send(32'h1234_5678);
    idle();
    peek_start();
    check("idle_no_strobe", 32'(FrameStrobe), 32'd0);
    peek_end();
    // basic frame write
    send(W_SYNC);
    send(32'h0305_0002);
    send(32'hA5A5_A5A5);
    idle();
    peek_start();
    check("basic_strobe0", 32'(FrameStrobe), 32'h0000_0020);
    check("basic_data0", FrameData, 32'hA5A5_A5A5);
    check("basic_col", 32'(ColumnSelect), 32'd3);
    check("basic_ready_low", 32'(Ready), 32'd0);
    peek_end();
    send(32'h5A5A_5A5A);
    idle();
    peek_start();
    check("basic_strobe1", 32'(FrameStrobe), 32'h0000_0040);
    check("basic_data1", FrameData, 32'h5A5A_5A5A);
    peek_end();
    // back-to-back throughput
    send(32'h0200_0004);
    s0 = strobe_cnt;
    send(32'h1111_1111);
    send(32'h2222_2222);
    send(32'h3333_3333);
    send(32'h4444_4444);
    idle();
    repeat (3) @(posedge CLK);
    #2;
    check("thru_strobe_count", 32'(strobe_cnt - s0), 32'd4);
    // range errors
    send(32'h0013_0002);
    idle();
    peek_start();
    check("range_idx_error", 32'(Error), 32'd1);
    peek_end();
    send(32'h0000_0001);
    idle();
    peek_start();
    check("err_no_strobe", 32'(FrameStrobe), 32'd0);
    check("err_sticky", 32'(Error), 32'd1);
    peek_end();
    send(W_SYNC);
    idle();
    peek_start();
    check("err_cleared", 32'(Error), 32'd0);
    peek_end();
    send(32'h1000_0001);
    idle();
    peek_start();
    check("range_col_error", 32'(Error), 32'd1);
    peek_end();
    send(W_SYNC);
    // payload equal to desync value
    send(32'h0100_0001);
    send(W_DESYNC);
    idle();
    peek_start();
    check("payload_desync_data", FrameData, 32'hFAB0_FAB0);
    check("payload_desync_strobe", 32'(FrameStrobe), 32'h0000_0001);
    check("payload_desync_done", 32'(ConfigDone), 32'd0);
    peek_end();
    send(W_DESYNC);
    idle();
    peek_start();
    check("desync_done", 32'(ConfigDone), 32'd1);
    peek_end();
    // reset during the strobe cycle
    send(W_SYNC);
    send(32'h0400_0003);
    send(32'hDEAD_BEEF);
    idle();
    check("midrst_strobe_before", 32'(FrameStrobe), 32'h0000_0001);
    resetn = 1'b0;
    #1;
    check("midrst_strobe_dropped", 32'(FrameStrobe), 32'd0);
    check("midrst_ready", 32'(Ready), 32'd0);
    check("midrst_data", FrameData, 32'd0);
    check("midrst_col", 32'(ColumnSelect), 32'd0);
    peek_end();
    resetn = 1'b1;
    send(32'hCAFE_F00D);
    send(32'h0400_0001);
    idle();
    peek_start();
    check("postrst_ignored", 32'(FrameStrobe), 32'd0);
    check("postrst_data", FrameData, 32'd0);
    peek_end();
    // degenerate N=0 header
    send(W_SYNC);
    s0 = strobe_cnt;
    send(32'h0102_0000);
    send(W_DESYNC);
    idle();
    peek_start();
    check("degen_done", 32'(ConfigDone), 32'd1);
    check("degen_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    peek_end();
    // randomized stream against the model
    repeat (3000) begin
      WriteStrobe = ($urandom_range(0, 3) != 0);
      WriteData = rand_word();
      @(posedge CLK);
      #2;
    end
    idle();
    repeat (3) @(posedge CLK);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
